// File: rtl/mytimer_pkg.sv
// Shared types and parameter limits for the mytimer channel bank.
package mytimer_pkg;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

    localparam int WIDTH_MIN    = 2;
    localparam int WIDTH_MAX    = 32;
    localparam int NCH_MIN      = 1;
    localparam int NCH_MAX      = 16;
    localparam int PRESCALE_MIN = 1;
    localparam int PRESCALE_MAX = 65535;

endpackage

// File: rtl/mytimer_chan.sv
// Single down-counting timer channel: load, decrement on tick, auto-reload, one-cycle done.
module mytimer_chan
    import mytimer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic             start,
    input  logic [WIDTH-1:0] start_time,
    input  logic             periodic,
    input  logic             stop,
    output logic [WIDTH-1:0] timer,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] reload;
    mode_e            mode;

    // NOTE: non-blocking assignments keep every register update in this block
    // based on pre-edge values, so the priority chain below reads as written.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            timer  <= '0;
            reload <= '0;
            mode   <= MODE_ONESHOT;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // A start overrides stop and any coinciding expiry of the old run.
                reload <= start_time;
                mode   <= periodic ? MODE_PERIODIC : MODE_ONESHOT;
                timer  <= start_time;
                if (start_time == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    busy <= 1'b1;
                end
            end else if (stop) begin
                busy <= 1'b0;
            end else if (busy && tick) begin
                if (timer > WIDTH'(1)) begin
                    timer <= timer - WIDTH'(1);
                end else if (mode == MODE_PERIODIC) begin
                    timer <= reload;
                    done  <= 1'b1;
                end else begin
                    timer <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mytimer_bank.sv
// Bank of NCH independent timer channels sharing one prescaled tick.
module mytimer_bank
    import mytimer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NCH      = 4,
    parameter int PRESCALE = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NCH-1:0]       start_enable,
    input  logic [NCH*WIDTH-1:0] start_time,
    input  logic [NCH-1:0]       periodic,
    input  logic [NCH-1:0]       stop,
    output logic [NCH*WIDTH-1:0] timer,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_cnt;
    logic            tick;

    assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        mytimer_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk       (clk),
            .resetn    (resetn),
            .tick      (tick),
            .start     (start_enable[i]),
            .start_time(start_time[i*WIDTH +: WIDTH]),
            .periodic  (periodic[i]),
            .stop      (stop[i]),
            .timer     (timer[i*WIDTH +: WIDTH]),
            .busy      (busy[i]),
            .done      (done[i])
        );
    end

endmodule
